// File: rtl/wrapper_ahb_pkg.sv
// rtl/wrapper_ahb_pkg.sv - AHB encodings, initiator FSM state type and byte-swap helper
// Purpose: shared definitions for the wrapper AHB packet initiator slice.
// Contents: HTRANS/HSIZE/HRESP encodings, init_state_t, bswap32().
package wrapper_ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic       HRESP_ERROR   = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    RD_ADDR,
    RD_DATA,
    OUT_HOLD,
    ERR
  } init_state_t;

  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/wrapper_ahb_packet_initiator_if.sv
// rtl/wrapper_ahb_packet_initiator_if.sv - AHB-Lite manager bus bundle
// Purpose: groups the AHB-Lite manager signals of the packet initiator.
// Signals: HADDRM, HTRANSM, HSIZEM, HWRITEM, HWDATAM (manager -> target);
//          HREADYM, HRESPM, HRDATAM (target -> manager).
// Modports: master (initiator side), slave (target side).
interface wrapper_ahb_packet_initiator_if #(
  parameter int ADDRWIDTH = 12
);

  logic [ADDRWIDTH-1:0] HADDRM;
  logic [1:0]           HTRANSM;
  logic [2:0]           HSIZEM;
  logic                 HWRITEM;
  logic [31:0]          HWDATAM;
  logic                 HREADYM;
  logic                 HRESPM;
  logic [31:0]          HRDATAM;

  modport master (
    output HADDRM, HTRANSM, HSIZEM, HWRITEM, HWDATAM,
    input  HREADYM, HRESPM, HRDATAM
  );

  modport slave (
    input  HADDRM, HTRANSM, HSIZEM, HWRITEM, HWDATAM,
    output HREADYM, HRESPM, HRDATAM
  );

endinterface

// File: rtl/wrapper_packet_word_shifter.sv
// rtl/wrapper_packet_word_shifter.sv - packet register with 32-bit MS-first word shifting
// Purpose: holds a packet; load replaces it, shift moves it one word towards the
//          MS end and inserts shift_in at the LS word.
// Ports: clk, resetn (sync, active low), load/load_data, shift/shift_in,
//        data (whole register), ms_word (current MS word).
module wrapper_packet_word_shifter #(
  parameter int WIDTH = 512
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift,
  input  logic [31:0]      shift_in,
  output logic [WIDTH-1:0] data,
  output logic [31:0]      ms_word
);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      data <= '0;
    end else if (load) begin
      data <= load_data;
    end else if (shift) begin
      // Shift-then-OR keeps this legal for a single-word (WIDTH == 32) packet.
      data <= (data << 32) | WIDTH'(shift_in);
    end
  end

  assign ms_word = data[WIDTH-1 -: 32];

endmodule

// File: rtl/wrapper_ahb_packet_initiator.sv
// rtl/wrapper_ahb_packet_initiator.sv - AHB-Lite manager moving packets to/from an accelerator wrapper
// Purpose: serialises input packets into 32-bit AHB writes to the input-port
//          region and assembles 32-bit AHB reads from the output-port region
//          into output packets, paced by in_data_req/out_data_req.
// Ports: HCLK, HRESETn (sync, active low); ahb (manager modport);
//        in_packet/in_packet_last/in_packet_valid/in_packet_ready;
//        out_packet/out_packet_valid/out_packet_ready;
//        in_data_req, out_data_req; bus_error (sticky).
// Build option: WRAPPER_AHB_INIT_BYTESWAP_EN reverses bytes within every word
//               on HWDATAM and HRDATAM.
module wrapper_ahb_packet_initiator
  import wrapper_ahb_pkg::*;
#(
  parameter int ADDRWIDTH      = 12,
  parameter int INPACKETWIDTH  = 512,
  parameter int OUTPACKETWIDTH = 256,
  parameter int INPORTADDR     = 'h000,
  parameter int OUTPORTADDR    = 'h800
) (
  input  logic                          HCLK,
  input  logic                          HRESETn,
  wrapper_ahb_packet_initiator_if.master ahb,
  input  logic [INPACKETWIDTH-1:0]      in_packet,
  input  logic                          in_packet_last,
  input  logic                          in_packet_valid,
  output logic                          in_packet_ready,
  output logic [OUTPACKETWIDTH-1:0]     out_packet,
  output logic                          out_packet_valid,
  input  logic                          out_packet_ready,
  input  logic                          in_data_req,
  input  logic                          out_data_req,
  output logic                          bus_error
);

  localparam int WORDS_IN  = INPACKETWIDTH / 32;
  localparam int WORDS_OUT = OUTPACKETWIDTH / 32;
  localparam int WORDS_MAX = (WORDS_IN > WORDS_OUT) ? WORDS_IN : WORDS_OUT;
  localparam int CNT_W     = (WORDS_MAX > 1) ? $clog2(WORDS_MAX) : 1;
  // Last packet of a message lands in the top packet slot of the input region.
  localparam int LAST_BASE = OUTPORTADDR - INPACKETWIDTH / 8;

  init_state_t          state;
  logic [CNT_W-1:0]     word_cnt;
  logic [CNT_W-1:0]     cnt_next;
  logic                 last_q;
  logic                 wr_load;
  logic                 wr_shift;
  logic                 rd_shift;
  logic                 beat_ok;
  logic [31:0]          wr_word;
  logic [31:0]          rd_word_in;
  logic [INPACKETWIDTH-1:0] wr_data_unused;
  logic [31:0]          rd_ms_unused;

  function automatic logic [31:0] fix_word(input logic [31:0] w);
`ifdef WRAPPER_AHB_INIT_BYTESWAP_EN
    return bswap32(w);
`else
    return w;
`endif
  endfunction

  function automatic logic [ADDRWIDTH-1:0] wr_addr(input logic last, input logic [CNT_W-1:0] idx);
    int base;
    base = last ? LAST_BASE : INPORTADDR;
    return ADDRWIDTH'(base + 4 * int'(idx));
  endfunction

  function automatic logic [ADDRWIDTH-1:0] rd_addr(input logic [CNT_W-1:0] idx);
    return ADDRWIDTH'(OUTPORTADDR + 4 * int'(idx));
  endfunction

  assign cnt_next   = word_cnt + 1'b1;
  assign beat_ok    = ahb.HREADYM && (ahb.HRESPM != HRESP_ERROR);
  // Must mirror the IDLE write-arbitration branch below so the packet is
  // captured on the same edge as the accept pulse.
  assign wr_load    = (state == IDLE) && in_packet_valid && in_data_req;
  assign wr_shift   = (state == WR_DATA) && beat_ok;
  assign rd_shift   = (state == RD_DATA) && beat_ok;
  assign rd_word_in = fix_word(ahb.HRDATAM);
  assign ahb.HSIZEM = HSIZE_WORD;

  wrapper_packet_word_shifter #(.WIDTH(INPACKETWIDTH)) u_wr_shifter (
    .clk       (HCLK),
    .resetn    (HRESETn),
    .load      (wr_load),
    .load_data (in_packet),
    .shift     (wr_shift),
    .shift_in  (32'h0),
    .data      (wr_data_unused),
    .ms_word   (wr_word)
  );

  // out_packet only moves during RD_DATA, so it is stable throughout OUT_HOLD.
  wrapper_packet_word_shifter #(.WIDTH(OUTPACKETWIDTH)) u_rd_shifter (
    .clk       (HCLK),
    .resetn    (HRESETn),
    .load      (1'b0),
    .load_data ({OUTPACKETWIDTH{1'b0}}),
    .shift     (rd_shift),
    .shift_in  (rd_word_in),
    .data      (out_packet),
    .ms_word   (rd_ms_unused)
  );

  // Address-phase outputs are set on the edge entering *_ADDR, so HTRANSM is
  // NONSEQ for exactly the *_ADDR cycle and IDLE during every data phase.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state            <= IDLE;
      ahb.HTRANSM      <= HTRANS_IDLE;
      ahb.HADDRM       <= '0;
      ahb.HWRITEM      <= 1'b0;
      ahb.HWDATAM      <= '0;
      in_packet_ready  <= 1'b0;
      out_packet_valid <= 1'b0;
      bus_error        <= 1'b0;
      word_cnt         <= '0;
      last_q           <= 1'b0;
    end else begin
      in_packet_ready <= 1'b0;
      unique case (state)
        IDLE: begin
          if (wr_load) begin
            in_packet_ready <= 1'b1;
            last_q          <= in_packet_last;
            word_cnt        <= '0;
            ahb.HTRANSM     <= HTRANS_NONSEQ;
            ahb.HADDRM      <= wr_addr(in_packet_last, {CNT_W{1'b0}});
            ahb.HWRITEM     <= 1'b1;
            state           <= WR_ADDR;
          end else if (out_data_req && !out_packet_valid) begin
            word_cnt    <= '0;
            ahb.HTRANSM <= HTRANS_NONSEQ;
            ahb.HADDRM  <= rd_addr({CNT_W{1'b0}});
            ahb.HWRITEM <= 1'b0;
            state       <= RD_ADDR;
          end
        end
        WR_ADDR: begin
          ahb.HTRANSM <= HTRANS_IDLE;
          ahb.HWDATAM <= fix_word(wr_word);
          state       <= WR_DATA;
        end
        WR_DATA: begin
          if (ahb.HREADYM) begin
            if (ahb.HRESPM == HRESP_ERROR) begin
              bus_error <= 1'b1;
              state     <= ERR;
            end else if (word_cnt == CNT_W'(WORDS_IN - 1)) begin
              state <= IDLE;
            end else begin
              word_cnt    <= cnt_next;
              ahb.HTRANSM <= HTRANS_NONSEQ;
              ahb.HADDRM  <= wr_addr(last_q, cnt_next);
              state       <= WR_ADDR;
            end
          end
        end
        RD_ADDR: begin
          ahb.HTRANSM <= HTRANS_IDLE;
          state       <= RD_DATA;
        end
        RD_DATA: begin
          if (ahb.HREADYM) begin
            if (ahb.HRESPM == HRESP_ERROR) begin
              bus_error <= 1'b1;
              state     <= ERR;
            end else if (word_cnt == CNT_W'(WORDS_OUT - 1)) begin
              out_packet_valid <= 1'b1;
              state            <= OUT_HOLD;
            end else begin
              word_cnt    <= cnt_next;
              ahb.HTRANSM <= HTRANS_NONSEQ;
              ahb.HADDRM  <= rd_addr(cnt_next);
              state       <= RD_ADDR;
            end
          end
        end
        OUT_HOLD: begin
          if (out_packet_ready) begin
            out_packet_valid <= 1'b0;
            state            <= IDLE;
          end
        end
        ERR: begin
          state <= ERR;
        end
        default: begin
          state <= ERR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wrapper_ahb_packet_initiator.sv
// tb/tb_wrapper_ahb_packet_initiator.sv - directed self-checking bench for wrapper_ahb_packet_initiator
// Purpose: drives packets and an AHB target model with programmable wait
//          states and error injection, and checks bus traffic and packets.
module tb_wrapper_ahb_packet_initiator;
  import wrapper_ahb_pkg::*;

  localparam int AW   = 12;
  localparam int INW  = 512;
  localparam int OUTW = 256;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  wrapper_ahb_packet_initiator_if #(.ADDRWIDTH(AW)) ahb_bus ();

  logic [INW-1:0]  in_packet = '0;
  logic            in_packet_last = 1'b0;
  logic            in_packet_valid = 1'b0;
  logic            in_packet_ready;
  logic [OUTW-1:0] out_packet;
  logic            out_packet_valid;
  logic            out_packet_ready = 1'b0;
  logic            in_data_req = 1'b0;
  logic            out_data_req = 1'b0;
  logic            bus_error;

  wrapper_ahb_packet_initiator #(
    .ADDRWIDTH(AW), .INPACKETWIDTH(INW), .OUTPACKETWIDTH(OUTW),
    .INPORTADDR('h000), .OUTPORTADDR('h800)
  ) dut (
    .HCLK             (clk),
    .HRESETn          (resetn),
    .ahb              (ahb_bus),
    .in_packet        (in_packet),
    .in_packet_last   (in_packet_last),
    .in_packet_valid  (in_packet_valid),
    .in_packet_ready  (in_packet_ready),
    .out_packet       (out_packet),
    .out_packet_valid (out_packet_valid),
    .out_packet_ready (out_packet_ready),
    .in_data_req      (in_data_req),
    .out_data_req     (out_data_req),
    .bus_error        (bus_error)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [AW-1:0] addr_q[$];
  bit            wr_q[$];
  logic [31:0]   wdata_q[$];
  int  txn_cnt, rd_idx, wait_states, err_idx;
  bit  dp_pending, dp_write;
  int  dp_wait;

  task automatic check_val(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input logic [31:0] w);
`ifdef WRAPPER_AHB_INIT_BYTESWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  function automatic logic [31:0] pat_word(input int k);
    return {16'(k + 1), 16'(16 - k)};
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_log();
    addr_q.delete();
    wr_q.delete();
    wdata_q.delete();
    txn_cnt = 0;
    rd_idx  = 0;
  endtask

  // AHB target: logs address phases, inserts wait states, returns read data.
  task automatic target_loop();
    ahb_bus.HREADYM = 1'b1;
    ahb_bus.HRESPM  = 1'b0;
    ahb_bus.HRDATAM = '0;
    dp_pending = 0;
    forever begin
      @(negedge clk);
      if (dp_pending) begin
        if (dp_wait > 0) begin
          ahb_bus.HREADYM = 1'b0;
          dp_wait--;
        end else begin
          ahb_bus.HREADYM = 1'b1;
          ahb_bus.HRESPM  = (txn_cnt == err_idx);
          if (dp_write) wdata_q.push_back(ahb_bus.HWDATAM);
          else begin
            ahb_bus.HRDATAM = 32'hA000_0000 + 32'(rd_idx);
            rd_idx++;
          end
          txn_cnt++;
          dp_pending = 0;
        end
      end else begin
        ahb_bus.HREADYM = 1'b1;
        ahb_bus.HRESPM  = 1'b0;
      end
      if (ahb_bus.HTRANSM == HTRANS_NONSEQ) begin
        addr_q.push_back(ahb_bus.HADDRM);
        wr_q.push_back(ahb_bus.HWRITEM);
        dp_pending = 1;
        dp_write   = ahb_bus.HWRITEM;
        dp_wait    = wait_states;
      end
    end
  endtask

  task automatic wait_txn(input int n, input string tag);
    for (int i = 0; i < 1000 && txn_cnt < n; i++) tick();
    check_val(tag, txn_cnt >= n, 1);
  endtask

  task automatic send_packet(input logic [INW-1:0] p, input logic last);
    in_packet = p; in_packet_last = last; in_packet_valid = 1'b1; in_data_req = 1'b1;
    for (int i = 0; i < 50 && !in_packet_ready; i++) tick();
    check_val("accept_seen", in_packet_ready, 1);
    in_packet_valid = 1'b0; in_data_req = 1'b0;
  endtask

  task automatic wait_out_valid(input string tag);
    for (int i = 0; i < 400 && !out_packet_valid; i++) tick();
    check_val(tag, out_packet_valid, 1);
  endtask

  logic [INW-1:0]  pkt_a, pkt_b;
  logic [OUTW-1:0] exp_rd;
  int t1, t2, highs;
  bit saw_busy, saw_ready;

  initial begin
    wait_states = 0;
    err_idx = -1;
    clear_log();
    fork
      target_loop();
    join_none

    for (int k = 0; k < 16; k++) pkt_a[INW-1-32*k -: 32] = pat_word(k);
    pkt_b = '0;
    pkt_b[INW-1 -: 32] = 32'h1122_3344;
    for (int k = 0; k < 8; k++) exp_rd[OUTW-1-32*k -: 32] = exp_word(32'hA000_0000 + 32'(k));

    repeat (3) tick();
    check_val("rst_htrans", ahb_bus.HTRANSM, HTRANS_IDLE);
    check_val("rst_haddr", ahb_bus.HADDRM, 0);
    check_val("rst_hwrite", ahb_bus.HWRITEM, 0);
    check_val("rst_hsize", ahb_bus.HSIZEM, 3'b010);
    check_val("rst_hwdata", ahb_bus.HWDATAM, 0);
    check_val("rst_in_ready", in_packet_ready, 0);
    check_val("rst_out_packet", out_packet, 0);
    check_val("rst_out_valid", out_packet_valid, 0);
    check_val("rst_bus_error", bus_error, 0);
    resetn = 1'b1;
    tick();

    // Non-last write, zero wait; valid held so the re-accept marks return to IDLE.
    clear_log();
    in_packet = pkt_a; in_packet_last = 1'b0; in_packet_valid = 1'b1; in_data_req = 1'b1;
    t1 = -1; t2 = -1; highs = 0;
    for (int c = 1; c <= 80 && t2 < 0; c++) begin
      tick();
      if (in_packet_ready) begin
        if (t1 < 0) begin t1 = c; highs++; end
        else t2 = c;
      end
    end
    in_packet_valid = 1'b0; in_data_req = 1'b0;
    check_val("wr_accept_cycle", t1, 1);
    check_val("wr_idle_after_33", t2 - t1, 33);
    check_val("wr_ready_once", highs, 1);
    wait_txn(32, "wr_timeout");
    for (int k = 0; k < 16; k++) begin
      check_val($sformatf("wr_addr%0d", k), addr_q[k], 12'(4 * k));
      check_val($sformatf("wr_write%0d", k), wr_q[k], 1);
      check_val($sformatf("wr_data%0d", k), wdata_q[k], exp_word(pat_word(k)));
    end
    check_val("wr_word0", wdata_q[0], exp_word(32'h0001_0010));
    check_val("wr_word15", wdata_q[15], exp_word(32'h0010_0001));
    tick();

    // Last packet of a message: top slot of the input region.
    clear_log();
    send_packet(pkt_a, 1'b1);
    wait_txn(16, "last_timeout");
    repeat (4) tick();
    check_val("last_count", addr_q.size(), 16);
    for (int k = 0; k < 16; k++)
      check_val($sformatf("last_addr%0d", k), addr_q[k], 12'('h7C0 + 4 * k));
    check_val("last_data3", wdata_q[3], exp_word(32'h0004_000D));

    // Read with 2 wait states per word; consumer stalls for 5 cycles.
    clear_log();
    wait_states = 2;
    out_data_req = 1'b1;
    wait_out_valid("rd_timeout");
    out_data_req = 1'b0;
    check_val("rd_count", addr_q.size(), 8);
    for (int k = 0; k < 8; k++) begin
      check_val($sformatf("rd_addr%0d", k), addr_q[k], 12'('h800 + 4 * k));
      check_val($sformatf("rd_write%0d", k), wr_q[k], 0);
    end
    check_val("rd_packet", out_packet, exp_rd);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_val("rd_hold_valid", out_packet_valid, 1);
      check_val("rd_hold_data", out_packet, exp_rd);
    end
    out_packet_ready = 1'b1;
    tick();
    check_val("rd_valid_clear", out_packet_valid, 0);
    out_packet_ready = 1'b0;
    wait_states = 0;
    tick();

    // Arbitration: write and read requested together; write runs to completion first.
    clear_log();
    in_packet = pkt_a; in_packet_last = 1'b0;
    in_packet_valid = 1'b1; in_data_req = 1'b1; out_data_req = 1'b1;
    for (int i = 0; i < 50 && !in_packet_ready; i++) tick();
    check_val("arb_accept", in_packet_ready, 1);
    in_packet_valid = 1'b0; in_data_req = 1'b0;
    wait_out_valid("arb_timeout");
    out_data_req = 1'b0;
    check_val("arb_total", addr_q.size(), 24);
    check_val("arb_wr_count", wdata_q.size(), 16);
    check_val("arb_w15_write", wr_q[15], 1);
    check_val("arb_r0_read", wr_q[16], 0);
    check_val("arb_r0_addr", addr_q[16], 12'h800);
    out_packet_ready = 1'b1;
    tick();
    out_packet_ready = 1'b0;
    tick();

    // Error on write word 3: sticky error, bus idles, reset recovers.
    clear_log();
    err_idx = 3;
    send_packet(pkt_a, 1'b0);
    for (int i = 0; i < 100 && !bus_error; i++) tick();
    check_val("err_flag", bus_error, 1);
    err_idx = -1;
    saw_busy = 0; saw_ready = 0;
    in_packet_valid = 1'b1; in_data_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (ahb_bus.HTRANSM != HTRANS_IDLE) saw_busy = 1;
      if (in_packet_ready) saw_ready = 1;
    end
    in_packet_valid = 1'b0; in_data_req = 1'b0;
    check_val("err_addr_count", addr_q.size(), 4);
    check_val("err_htrans_idle", saw_busy, 0);
    check_val("err_no_accept", saw_ready, 0);
    check_val("err_sticky", bus_error, 1);
    resetn = 1'b0;
    tick();
    check_val("err_rst_clear", bus_error, 0);
    check_val("err_rst_htrans", ahb_bus.HTRANSM, HTRANS_IDLE);
    resetn = 1'b1;
    tick();

    // Recovery plus byte-lane check on a single marked word.
    clear_log();
    send_packet(pkt_b, 1'b0);
    wait_txn(16, "swap_timeout");
    check_val("swap_word0", wdata_q[0], exp_word(32'h1122_3344));
    check_val("swap_word1", wdata_q[1], 0);
    check_val("swap_addr0", addr_q[0], 12'h000);
`ifdef WRAPPER_AHB_INIT_BYTESWAP_EN
    check_val("swap_literal", wdata_q[0], 32'h4433_2211);
`endif
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
